// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag sequencer for a synchronous FIFO built on an
// external simple dual-port block RAM (one write port, one read port with
// a registered read address). Owns the pointers, occupancy, status flags
// and sticky error flags; the RAM sits alongside this block.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 19,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wa,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_rden,
    output logic [ADDR_WIDTH-1:0] ram_ra,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(AF_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_dout_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Status flags come straight from the registered pointers
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // Accept decisions use start-of-cycle state only: a pop never frees room
    // for a same-cycle push, and a push never feeds a same-cycle pop
    assign w_push_ok = push & ~w_full;
    assign w_pop_ok  = pop & ~w_empty;

    // RAM port drive; reset blocks both enables so nothing moves during rst
    assign ram_wren = w_push_ok & ~rst;
    assign ram_rden = w_pop_ok & ~rst;
    assign ram_wa   = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_ra   = r_rd_ptr[ADDR_WIDTH-1:0];
    assign ram_di   = din;

    // The RAM presents the word at the captured read address one cycle later
    assign dout        = ram_do;
    assign dout_valid  = r_dout_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign almost_full = (r_count >= AF_THRESH);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Pointer advance on accepted push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read-data valid pulse, one cycle after each accepted pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_ok;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
